modn_updown_counter: RTL

MODN_UPDOWN_COUNTER -- requirements
Module: modn_updown_counter

---
 rtl/modn_updown_counter_pkg.sv | 14 +
 rtl/modn_updown_counter_digit.sv | 61 ++++++
 rtl/modn_updown_counter.sv | 72 +++++++
 3 files changed

// File: rtl/modn_updown_counter_pkg.sv
// Shared definitions for the mod-N up/down counter: direction encoding and
// the terminal-value helper used by every digit.
package modn_updown_counter_pkg;

    // Direction encoding on the 'up' input.
    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Value at which a digit produces its carry/borrow for the given direction.
    function automatic int term_val(input int modulus, input logic up);
        return (up == DIR_UP) ? (modulus - 1) : 0;
    endfunction

endpackage

// File: rtl/modn_updown_counter_digit.sv
// One WIDTH-bit mod-MODULUS up/down digit with synchronous parallel load.
// Illegal load fields (>= MODULUS) are replaced by 0 and flagged on ld_bad.
module modn_digit
    import modn_updown_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             step,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] value,
    output logic             at_term,
    output logic             ld_bad
);

    if (WIDTH < 1 || MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_param
        $fatal(1, "modn_digit: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
    end

    localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(term_val(MODULUS, DIR_UP));
    localparam logic [WIDTH-1:0] TERM_DN = WIDTH'(term_val(MODULUS, DIR_DOWN));
    // One extra bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             illegal;

    assign illegal = ({1'b0, ld_val} >= MOD_EXT);
    assign ld_bad  = ld & illegal;
    assign at_term = (value_q == ((up == DIR_UP) ? TERM_UP : TERM_DN));
    assign value   = value_q;

    // Next digit value: load beats step; steps wrap at the terminal value.
    always_comb begin
        value_d = value_q;
        if (ld) begin
            value_d = illegal ? '0 : ld_val;
        end else if (step) begin
            if (up == DIR_UP) begin
                value_d = (value_q == TERM_UP) ? '0 : value_q + WIDTH'(1);
            end else begin
                value_d = (value_q == TERM_DN) ? TERM_UP : value_q - WIDTH'(1);
            end
        end
    end

    // Digit register, cleared asynchronously.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/modn_updown_counter.sv
// Cascaded DIGITS x mod-MODULUS synchronous up/down counter.
// All digits share one clock; the carry chain is purely combinational so the
// full-count wrap lands on q in a single edge. tc is gated only by en (not by
// load), which lets a higher counter instance use it directly as its enable.
module modn_updown_counter
    import modn_updown_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int DIGITS  = 2
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [DIGITS*WIDTH-1:0] load_val,
    output logic [DIGITS*WIDTH-1:0] q,
    output logic                    tc,
    output logic                    load_err
);

    if (WIDTH < 1 || MODULUS < 2 || MODULUS > 2 ** WIDTH || DIGITS < 1) begin : g_bad_param
        $fatal(1, "modn_updown_counter: illegal WIDTH=%0d MODULUS=%0d DIGITS=%0d",
               WIDTH, MODULUS, DIGITS);
    end

    logic [DIGITS-1:0] step;
    logic [DIGITS-1:0] at_term;
    logic [DIGITS-1:0] ld_bad;
    logic              load_err_q;
    logic              load_err_d;

    // Digit 0 steps on every enabled, non-load edge.
    assign step[0] = en & ~load;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        modn_digit #(
            .WIDTH  (WIDTH),
            .MODULUS(MODULUS)
        ) u_digit (
            .clk    (clk),
            .clear  (clear),
            .step   (step[i]),
            .up     (up),
            .ld     (load),
            .ld_val (load_val[i*WIDTH +: WIDTH]),
            .value  (q[i*WIDTH +: WIDTH]),
            .at_term(at_term[i]),
            .ld_bad (ld_bad[i])
        );

        // A higher digit steps only when everything below it is terminal.
        if (i > 0) begin : g_chain
            assign step[i] = step[i-1] & at_term[i-1];
        end
    end

    assign tc         = en & (&at_term);
    assign load_err_d = |ld_bad;
    assign load_err   = load_err_q;

    // Illegal-load flag lives for exactly one cycle after the offending load.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

endmodule
